// File: rtl/lcd_capture_pkg.sv
// lcd_capture_pkg
//   Shared definitions for the LCD RGB capture block: register word offsets
//   (byte address bits [9:2]), STATUS bit positions, capture FSM encoding and
//   the per-pixel checksum helpers (additive sum and CRC-32 step).
package lcd_capture_pkg;

    // Register word offsets (byte address >> 2)
    localparam logic [7:0] REG_CTRL     = 8'h00;
    localparam logic [7:0] REG_STATUS   = 8'h01;
    localparam logic [7:0] REG_LINE_SEL = 8'h02;
    localparam logic [7:0] REG_PIXELS   = 8'h03;
    localparam logic [7:0] REG_LINES    = 8'h04;
    localparam logic [7:0] REG_CHECKSUM = 8'h05;
    localparam logic [7:0] REG_FRAMES   = 8'h06;

    // Line buffer window: byte 0x040.. -> addr[9:6] == 4'b0001, word = addr[5:2]
    localparam logic [3:0] LINEBUF_PAGE = 4'b0001;

    // STATUS bit indices
    localparam int ST_DONE    = 0;
    localparam int ST_LOST    = 1;
    localparam int ST_OVF     = 2;
    localparam int ST_LINE_OK = 3;

    // CRC-32 parameters (MSB-first, no final xor)
    localparam logic [31:0] CRC_POLY = 32'h04C11DB7;
    localparam logic [31:0] CRC_INIT = 32'hFFFFFFFF;

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_WAIT_VB   = 2'd1,
        S_ACTIVE    = 2'd2,
        S_FRAME_END = 2'd3
    } cap_state_t;

    // One pixel into the CRC: 24 bits {r,g,b}, red[7] first.
    function automatic logic [31:0] crc32_px(input logic [31:0] crc, input logic [23:0] px);
        logic [31:0] c;
        c = crc;
        for (int i = 23; i >= 0; i--) begin
            if (c[31] ^ px[i]) c = {c[30:0], 1'b0} ^ CRC_POLY;
            else               c = {c[30:0], 1'b0};
        end
        return c;
    endfunction

    // One pixel into the wrapping additive checksum.
    function automatic logic [31:0] sum_px(input logic [31:0] acc, input logic [23:0] px);
        return acc + {8'd0, px};
    endfunction

endpackage

// File: rtl/lcd_edge_sync.sv
// lcd_edge_sync
//   Brings the asynchronous LCD pins into the clk domain. dclk goes through two
//   synchroniser flops; a third flop holds the previous synchronised level and
//   the rising edge is registered alongside de/rgb so that o_edge, o_de and o_rgb
//   are aligned (three clk from pin to outputs).
// Ports
//   i_clk, i_rst   system clock, synchronous active-high reset
//   i_dclk         LCD pixel clock (async)
//   i_de, i_rgb    data enable and {red,green,blue} (async)
//   o_edge         one-clk pulse per dclk rising edge
//   o_de, o_rgb    de/rgb as sampled at that edge
module lcd_edge_sync (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_dclk,
    input  logic        i_de,
    input  logic [23:0] i_rgb,
    output logic        o_edge,
    output logic        o_de,
    output logic [23:0] o_rgb
);
    logic [1:0]  r_dclk_sync;
    logic        r_dclk_prev;
    logic [1:0]  r_de_sync;
    logic [23:0] r_rgb_s1;
    logic [23:0] r_rgb_s2;
    logic        r_edge;
    logic        r_de;
    logic [23:0] r_rgb;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_dclk_sync <= '0;
            r_dclk_prev <= 1'b0;
            r_de_sync   <= '0;
            r_rgb_s1    <= '0;
            r_rgb_s2    <= '0;
            r_edge      <= 1'b0;
            r_de        <= 1'b0;
            r_rgb       <= '0;
        end else begin
            r_dclk_sync <= {r_dclk_sync[0], i_dclk};
            r_de_sync   <= {r_de_sync[0], i_de};
            r_rgb_s1    <= i_rgb;
            r_rgb_s2    <= r_rgb_s1;
            r_dclk_prev <= r_dclk_sync[1];
            // third stage: edge and data leave together
            r_edge      <= r_dclk_sync[1] & ~r_dclk_prev;
            r_de        <= r_de_sync[1];
            r_rgb       <= r_rgb_s2;
        end
    end

    assign o_edge = r_edge;
    assign o_de   = r_de;
    assign o_rgb  = r_rgb;
endmodule

// File: rtl/lcd_rgb_capture.sv
// lcd_rgb_capture
//   Sink for the parallel RGB/DE LCD link. Counts pixels and lines per frame,
//   accumulates a per-frame checksum, grabs red[7] of one selected line as a
//   1bpp line buffer, and exposes results on a PicoRV-style bus slave.
// Configuration macro
//   LCD_CAPTURE_CRC_EN : CHECKSUM is CRC-32 instead of the additive sum.
// Ports
//   clk, rst            system clock, synchronous active-high reset
//   select/wstrb/addr/data_i   bus request (wstrb==0 is a read)
//   ready/data_o        one-clk acknowledge and read data
//   dclk/de/red/green/blue     LCD link inputs (async to clk, dclk <= clk/4)
module lcd_rgb_capture
    import lcd_capture_pkg::*;
#(
    parameter int H_MAX      = 480,
    parameter int VBLANK_MIN = 600,
    parameter int LINE_WORDS = 15
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        select,
    input  logic [3:0]  wstrb,
    input  logic [9:0]  addr,
    input  logic [31:0] data_i,
    output logic        ready,
    output logic [31:0] data_o,
    input  logic        dclk,
    input  logic        de,
    input  logic [7:0]  red,
    input  logic [7:0]  green,
    input  logic [7:0]  blue
);
    logic        w_edge;
    logic        w_de;
    logic [23:0] w_rgb;
    logic [31:0] w_csum_next;

    lcd_edge_sync u_sync (
        .i_clk  (clk),
        .i_rst  (rst),
        .i_dclk (dclk),
        .i_de   (de),
        .i_rgb  ({red, green, blue}),
        .o_edge (w_edge),
        .o_de   (w_de),
        .o_rgb  (w_rgb)
    );

    cap_state_t  r_state, w_state_nxt;
    logic        r_ready;
    logic [31:0] r_data_o;
    logic        r_en, r_oneshot;
    logic [8:0]  r_line_sel;
    logic [3:0]  r_status;
    logic [31:0] r_pixels, r_lines, r_checksum, r_frames;
    logic [9:0]  r_x;
    logic [31:0] r_y, r_pix_cnt, r_csum;
    logic [15:0] r_vb_cnt;
    logic        r_de_prev;
    logic        r_line_hit;
    logic [31:0] r_linebuf [LINE_WORDS];

`ifdef LCD_CAPTURE_CRC_EN
    localparam logic [31:0] CSUM_INIT = CRC_INIT;
    assign w_csum_next = crc32_px(r_csum, w_rgb);
`else
    localparam logic [31:0] CSUM_INIT = 32'h0;
    assign w_csum_next = sum_px(r_csum, w_rgb);
`endif

    logic        w_acc, w_wr;
    logic        w_vb_reach, w_pix, w_pix_in, w_lb_we;
    logic [3:0]  w_st_set, w_st_clr;
    logic [31:0] w_rdata;
    logic        w_unused;

    assign w_acc  = select & ~r_ready;
    assign w_wr   = w_acc & (|wstrb);
    assign w_unused = ^{addr[1:0], data_i[31:9]};

    // Frame end is the edge that brings the de=0 run exactly to VBLANK_MIN;
    // the counter then saturates so one long vblank yields one frame.
    assign w_vb_reach = w_edge & ~w_de & (r_vb_cnt == 16'(VBLANK_MIN - 1));
    assign w_pix      = r_en & (r_state == S_ACTIVE) & w_edge & w_de;
    assign w_pix_in   = r_x < 10'(H_MAX);
    assign w_lb_we    = w_pix & w_pix_in & (r_y == {23'd0, r_line_sel});

    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        if (!r_en) begin
            w_state_nxt = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE:      w_state_nxt = S_WAIT_VB;
                S_WAIT_VB:   if (w_vb_reach) w_state_nxt = S_ACTIVE;
                S_ACTIVE:    if (w_vb_reach) w_state_nxt = S_FRAME_END;
                S_FRAME_END: w_state_nxt = r_oneshot ? S_IDLE : S_ACTIVE;
                default:     w_state_nxt = S_IDLE;
            endcase
        end
    end

    // STATUS set/clear; hardware set takes priority over a same-clk clear.
    always_comb begin
        w_st_set = '0;
        w_st_clr = '0;
        if (w_pix && !w_pix_in) w_st_set[ST_OVF] = 1'b1;
        if (r_en && r_state == S_FRAME_END) begin
            w_st_set[ST_DONE]    = 1'b1;
            w_st_set[ST_LOST]    = r_status[ST_DONE];
            w_st_set[ST_LINE_OK] = r_line_hit;
        end
        if (w_wr && addr[9:2] == REG_STATUS && wstrb[0]) w_st_clr = data_i[3:0];
    end

    always_comb begin
        w_rdata = '0;
        case (addr[9:2])
            REG_CTRL:     w_rdata = {30'd0, r_oneshot, r_en};
            REG_STATUS:   w_rdata = {28'd0, r_status};
            REG_LINE_SEL: w_rdata = {23'd0, r_line_sel};
            REG_PIXELS:   w_rdata = r_pixels;
            REG_LINES:    w_rdata = r_lines;
            REG_CHECKSUM: w_rdata = r_checksum;
            REG_FRAMES:   w_rdata = r_frames;
            default: begin
                if (addr[9:6] == LINEBUF_PAGE && {28'd0, addr[5:2]} < 32'(LINE_WORDS))
                    w_rdata = r_linebuf[addr[5:2]];
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ready    <= 1'b0;
            r_data_o   <= '0;
            r_en       <= 1'b0;
            r_oneshot  <= 1'b0;
            r_line_sel <= '0;
            r_status   <= '0;
            r_pixels   <= '0;
            r_lines    <= '0;
            r_checksum <= '0;
            r_frames   <= '0;
            r_x        <= '0;
            r_y        <= '0;
            r_pix_cnt  <= '0;
            r_csum     <= CSUM_INIT;
            r_vb_cnt   <= '0;
            r_de_prev  <= 1'b0;
            r_line_hit <= 1'b0;
        end else begin
            r_ready  <= w_acc;
            r_data_o <= w_acc ? w_rdata : '0;
            r_status <= (r_status & ~w_st_clr) | w_st_set;

            if (!r_en) begin
                r_x        <= '0;
                r_y        <= '0;
                r_pix_cnt  <= '0;
                r_csum     <= CSUM_INIT;
                r_vb_cnt   <= '0;
                r_de_prev  <= 1'b0;
                r_line_hit <= 1'b0;
            end else begin
                case (r_state)
                    S_IDLE: r_vb_cnt <= '0;
                    S_WAIT_VB: begin
                        r_de_prev <= 1'b0;
                        if (w_edge) begin
                            if (w_de)
                                r_vb_cnt <= '0;
                            else if (r_vb_cnt != 16'(VBLANK_MIN))
                                r_vb_cnt <= r_vb_cnt + 16'd1;
                        end
                    end
                    S_ACTIVE: begin
                        if (w_edge) begin
                            r_de_prev <= w_de;
                            if (w_de) begin
                                r_vb_cnt  <= '0;
                                r_pix_cnt <= r_pix_cnt + 32'd1;
                                r_csum    <= w_csum_next;
                                if (r_x != 10'(H_MAX)) r_x <= r_x + 10'd1;
                                if (w_lb_we) r_line_hit <= 1'b1;
                            end else begin
                                // falling de closes a line
                                if (r_de_prev) begin
                                    r_y <= r_y + 32'd1;
                                    r_x <= '0;
                                end
                                if (r_vb_cnt != 16'(VBLANK_MIN)) r_vb_cnt <= r_vb_cnt + 16'd1;
                            end
                        end
                    end
                    S_FRAME_END: begin
                        r_pixels   <= r_pix_cnt;
                        r_lines    <= r_y;
                        r_checksum <= r_csum;
                        r_frames   <= r_frames + 32'd1;
                        r_x        <= '0;
                        r_y        <= '0;
                        r_pix_cnt  <= '0;
                        r_csum     <= CSUM_INIT;
                        r_line_hit <= 1'b0;
                        if (r_oneshot) begin
                            r_en      <= 1'b0;
                            r_oneshot <= 1'b0;
                        end
                    end
                    default: ;
                endcase
            end

            // bus writes come last so software wins over the oneshot auto-clear
            if (w_wr && addr[9:2] == REG_CTRL && wstrb[0]) begin
                r_en      <= data_i[0];
                r_oneshot <= data_i[1];
            end
            if (w_wr && addr[9:2] == REG_LINE_SEL) begin
                if (wstrb[0]) r_line_sel[7:0] <= data_i[7:0];
                if (wstrb[1]) r_line_sel[8]   <= data_i[8];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < LINE_WORDS; i++) r_linebuf[i] <= '0;
        end else if (w_lb_we) begin
            r_linebuf[r_x[8:5]][r_x[4:0]] <= w_rgb[23];
        end
    end

    assign ready  = r_ready;
    assign data_o = r_data_o;
endmodule
